// File: rtl/serial_word_rx.sv
// Serial start/data/stop deframer producing a parallel word plus one-cycle store strobe.
// Optional even-parity bit after the data bits: define SERIAL_WORD_RX_PARITY_EN.
module serial_word_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             tick,
  input  logic             rx,
  output logic [WIDTH-1:0] D,
  output logic             st,
  output logic             busy,
  output logic             frm_err,
  output logic             par_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BRK    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             st_q, st_d;
  logic             busy_q, busy_d;
  logic             frm_q, frm_d;
`ifdef SERIAL_WORD_RX_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             par_q, par_d;
`endif

  // State and output registers; clr discards any partial frame.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      st_q      <= 1'b0;
      busy_q    <= 1'b0;
      frm_q     <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
      par_bit_q <= 1'b0;
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      st_q      <= st_d;
      busy_q    <= busy_d;
      frm_q     <= frm_d;
`ifdef SERIAL_WORD_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      par_q     <= par_d;
`endif
    end
  end

  // Next-state logic: everything advances only on tick cycles.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    st_d      = 1'b0;
    frm_d     = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
    par_bit_d = par_bit_q;
    par_d     = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          // LSB-first line order: new bit enters the MSB and walks down.
          shift_d = WIDTH'({rx, shift_q} >> 1);
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef SERIAL_WORD_RX_PARITY_EN
        PARITY: begin
          par_bit_d = rx;
          state_d   = STOP;
        end
`endif
        STOP: begin
          if (rx) begin
            state_d = IDLE;
`ifdef SERIAL_WORD_RX_PARITY_EN
            if ((^shift_q) ^ par_bit_q) begin
              par_d = 1'b1;
            end else begin
              st_d   = 1'b1;
              word_d = shift_q;
            end
`else
            st_d   = 1'b1;
            word_d = shift_q;
`endif
          end else begin
            state_d = BRK;
            frm_d   = 1'b1;
          end
        end
        BRK: begin
          if (rx) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  assign D       = word_q;
  assign st      = st_q;
  assign busy    = busy_q;
  assign frm_err = frm_q;
`ifdef SERIAL_WORD_RX_PARITY_EN
  assign par_err = par_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx with a store-strobe scoreboard.
module tb_serial_word_rx;

  localparam int unsigned WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [31:0]      t;
  } ev_t;

  logic             clk;
  logic             clr;
  logic             tick;
  logic             rx;
  logic [WIDTH-1:0] D;
  logic             st;
  logic             busy;
  logic             frm_err;
  logic             par_err;

  int   errors = 0;
  int   checks = 0;
  int   frm_cnt = 0;
  int   par_cnt = 0;
  int   obs_rd = 0;
  int   last_t = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];

  serial_word_rx #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .clr     (clr),
    .tick    (tick),
    .rx      (rx),
    .D       (D),
    .st      (st),
    .busy    (busy),
    .frm_err (frm_err),
    .par_err (par_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: log every store strobe with its time, count error pulse cycles.
  always @(negedge clk) begin
    if (st === 1'b1) obs_q.push_back('{d: D, t: 32'($time)});
    if (frm_err === 1'b1) frm_cnt = frm_cnt + 1;
    if (par_err === 1'b1) par_cnt = par_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit period: tick for one clk, then three idle clks.
  task automatic send_bit(input logic b);
    @(negedge clk);
    rx     = b;
    tick   = 1'b1;
    last_t = int'($time);
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic pbit, input logic stopb);
    send_bit(1'b0);
    for (int i = 0; i < int'(WIDTH); i++) send_bit(w[i]);
`ifdef SERIAL_WORD_RX_PARITY_EN
    send_bit(pbit);
`else
    if (pbit === 1'bz) send_bit(1'b1);
`endif
    send_bit(stopb);
  endtask

  // Good frame whose strobe is expected one clk after the stop tick.
  task automatic good_frame(input logic [WIDTH-1:0] w);
    send_frame(w, ^w, 1'b1);
    exp_q.push_back('{d: w, t: 32'(last_t + 10)});
  endtask

  task automatic drain(input string tag);
    int n;
    n = obs_q.size() - obs_rd;
    chk({tag, "_st_count"}, 32'(n), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      ev_t e;
      ev_t o;
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd = obs_rd + 1;
      chk({tag, "_D"}, 32'(o.d), 32'(e.d));
      chk({tag, "_st_time"}, o.t, e.t);
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  initial begin
    int frm0;
    int par0;

    // Reset with the line low and tick active: nothing may start.
    clr  = 1'b1;
    tick = 1'b1;
    rx   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_D", 32'(D), 32'h0);
    chk("rst_st", 32'(st), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    clr  = 1'b0;
    tick = 1'b0;
    rx   = 1'b1;
    @(negedge clk);
    chk("rst_no_frame", 32'(busy), 32'h0);

    // Good frame 1101.
    send_bit(1'b0);
    chk("good_busy_mid", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) send_bit(i == 1 ? 1'b0 : 1'b1);
`ifdef SERIAL_WORD_RX_PARITY_EN
    send_bit(1'b1);
`endif
    send_bit(1'b1);
    exp_q.push_back('{d: 4'b1101, t: 32'(last_t + 10)});
    chk("good_busy_end", 32'(busy), 32'h0);
    drain("good");

    // Framing error followed by a held-low break.
    frm0 = frm_cnt;
    send_frame(4'b0011, 1'b0, 1'b0);
    chk("brk_busy", 32'(busy), 32'h1);
    repeat (3) send_bit(1'b0);
    chk("brk_busy_held", 32'(busy), 32'h1);
    send_bit(1'b1);
    chk("brk_exit_busy", 32'(busy), 32'h0);
    chk("frm_pulses", 32'(frm_cnt - frm0), 32'h1);
    chk("frm_D_hold", 32'(D), 32'hD);
    drain("frm");
    good_frame(4'b1010);
    drain("after_frm");

    // Back-to-back frames, strobes 24 clks apart.
    good_frame(4'b0001);
    good_frame(4'b1000);
    drain("b2b");

    // Reset after two data bits.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    clr = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("midrst_busy", 32'(busy), 32'h0);
    repeat (4) @(negedge clk);
    drain("midrst");
    good_frame(4'b0110);
    drain("after_midrst");

`ifdef SERIAL_WORD_RX_PARITY_EN
    good_frame(4'b0111);
    drain("par_good");
    par0 = par_cnt;
    send_frame(4'b0111, 1'b0, 1'b1);
    chk("par_pulses", 32'(par_cnt - par0), 32'h1);
    chk("par_D_hold", 32'(D), 32'h7);
    drain("par_bad");
`else
    par0 = 0;
    chk("par_tied", 32'(par_cnt - par0), 32'h0);
`endif
    chk("frm_total", 32'(frm_cnt), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
